// File: rtl/eth_phy_10g_defs.sv
// Shared 10GBASE-R PHY definitions: sync-header codes and the BER monitor
// state encodings.
package eth_phy_10g_defs;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_TEST   = 2'd1,
        ST_HI_BER = 2'd2
    } ber_state_t;

endpackage

// File: rtl/eth_phy_10g_rx_ber_timer.sv
// 125 us BER window timer: holds the reload value while loaded, counts down
// while enabled, and flags the terminal cycle while reloading in that same cycle.
module eth_phy_10g_rx_ber_timer #(
    parameter int COUNT = 19531
) (
    input  logic clk,
    input  logic i_rst,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int TW = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(COUNT - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (i_rst || load) begin
            count <= RELOAD;
        end else if (enable) begin
            count <= (count == '0) ? RELOAD : count - 1'b1;
        end
    end

    assign expire = enable && (count == '0);

endmodule

// File: rtl/eth_phy_10g_rx_ber_mon.sv
// 10GBASE-R RX BER monitor: counts invalid sync headers per 125 us window and
// declares high BER once the per-window count reaches BER_THRESH.
module eth_phy_10g_rx_ber_mon
    import eth_phy_10g_defs::*;
#(
    parameter int HDR_WIDTH   = 2,
    parameter int COUNT_125US = 19531,
    parameter int BER_THRESH  = 16
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic [HDR_WIDTH-1:0] i_serdes_rx_hdr,
    input  logic                 i_rx_block_lock,
    output logic                 o_rx_high_ber,
    output logic [5:0]           o_ber_count,
    output logic                 o_window_done
);

    localparam int CW = $clog2(BER_THRESH + 1);
    localparam logic [CW-1:0] THRESH_MAX = CW'(BER_THRESH);

    ber_state_t state, next_state;

    logic [CW-1:0] thresh_cnt, thresh_next;
    logic [5:0]    report_cnt, report_next;
    logic          run, load, expire, hdr_invalid;

    assign run  = i_rx_block_lock && (state != ST_INIT);
    assign load = !i_rx_block_lock || (state == ST_INIT);
    assign hdr_invalid = !((i_serdes_rx_hdr == HDR_WIDTH'(SYNC_DATA)) ||
                           (i_serdes_rx_hdr == HDR_WIDTH'(SYNC_CTRL)));

    eth_phy_10g_rx_ber_timer #(
        .COUNT (COUNT_125US)
    ) u_timer (
        .clk    (clk),
        .i_rst  (i_rst),
        .load   (load),
        .enable (run),
        .expire (expire)
    );

    // Counter values including this cycle's header, so the expiry cycle's header
    // belongs to the window that is closing.
    always_comb begin
        thresh_next = thresh_cnt;
        report_next = report_cnt;
        if (run && hdr_invalid) begin
            if (thresh_cnt != THRESH_MAX) thresh_next = thresh_cnt + 1'b1;
            if (report_cnt != 6'd63)      report_next = report_cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        if (!i_rx_block_lock) begin
            next_state = ST_INIT;
        end else begin
            case (state)
                ST_INIT:   next_state = ST_TEST;
                ST_TEST:   if (thresh_next == THRESH_MAX) next_state = ST_HI_BER;
                ST_HI_BER: if (expire && thresh_next != THRESH_MAX) next_state = ST_TEST;
                default:   next_state = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) state <= ST_INIT;
        else       state <= next_state;
    end

    // Loss of lock clears everything alongside reset; window counters restart
    // from zero on every expiry.
    always_ff @(posedge clk) begin
        if (i_rst || !i_rx_block_lock) begin
            thresh_cnt    <= '0;
            report_cnt    <= '0;
            o_rx_high_ber <= 1'b0;
            o_ber_count   <= '0;
            o_window_done <= 1'b0;
        end else begin
            o_window_done <= expire;
            o_rx_high_ber <= (next_state == ST_HI_BER);
            if (expire) begin
                o_ber_count <= report_next;
                thresh_cnt  <= '0;
                report_cnt  <= '0;
            end else begin
                thresh_cnt  <= thresh_next;
                report_cnt  <= report_next;
            end
        end
    end

endmodule

// File: tb/tb_eth_phy_10g_rx_ber_mon.sv
// Directed self-checking bench for the BER monitor with a 32-cycle window and
// a threshold of 16 invalid headers.
module tb_eth_phy_10g_rx_ber_mon;

    logic       clk = 1'b0;
    logic       i_rst;
    logic [1:0] i_serdes_rx_hdr;
    logic       i_rx_block_lock;
    logic       o_rx_high_ber;
    logic [5:0] o_ber_count;
    logic       o_window_done;

    int checks   = 0;
    int failures = 0;

    eth_phy_10g_rx_ber_mon #(
        .HDR_WIDTH   (2),
        .COUNT_125US (32),
        .BER_THRESH  (16)
    ) dut (
        .clk             (clk),
        .i_rst           (i_rst),
        .i_serdes_rx_hdr (i_serdes_rx_hdr),
        .i_rx_block_lock (i_rx_block_lock),
        .o_rx_high_ber   (o_rx_high_ber),
        .o_ber_count     (o_ber_count),
        .o_window_done   (o_window_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply one header, let one rising edge pass, sample 1 time unit later.
    task automatic drive(input logic [1:0] h, input logic l);
        i_serdes_rx_hdr = h;
        i_rx_block_lock = l;
        @(posedge clk);
        #1;
    endtask

    // n non-expiry cycles with lock held: no window pulse, fixed high-BER level.
    task automatic drive_n(input logic [1:0] h, input int n, input logic exp_hb, input string tag);
        for (int i = 0; i < n; i++) begin
            drive(h, 1'b1);
            chk({tag, "_done"}, {7'd0, o_window_done}, 8'd0);
            chk({tag, "_hb"},   {7'd0, o_rx_high_ber}, {7'd0, exp_hb});
        end
    endtask

    task automatic expect_end(input string tag, input logic exp_hb, input logic [5:0] exp_cnt);
        chk({tag, "_done"},  {7'd0, o_window_done}, 8'd1);
        chk({tag, "_hb"},    {7'd0, o_rx_high_ber}, {7'd0, exp_hb});
        chk({tag, "_count"}, {2'd0, o_ber_count},   {2'd0, exp_cnt});
    endtask

    initial begin
        i_rst = 1'b1;
        i_serdes_rx_hdr = 2'b01;
        i_rx_block_lock = 1'b0;
        repeat (3) drive(2'b01, 1'b0);
        chk("rst_hb",    {7'd0, o_rx_high_ber}, 8'd0);
        chk("rst_count", {2'd0, o_ber_count},   8'd0);
        chk("rst_done",  {7'd0, o_window_done}, 8'd0);

        // Lock acquisition cycle, then clean windows of data and control headers
        i_rst = 1'b0;
        drive(2'b01, 1'b1);
        chk("entry_done", {7'd0, o_window_done}, 8'd0);
        for (int w = 0; w < 6; w++) begin
            drive_n((w % 2) ? 2'b10 : 2'b01, 31, 1'b0, "clean");
            drive(2'b01, 1'b1);
            expect_end("clean_end", 1'b0, 6'd0);
        end

        // 16 invalid from window start: high BER right after the 16th
        drive_n(2'b11, 15, 1'b0, "burst_pre");
        drive(2'b11, 1'b1);
        chk("burst_hb_rise", {7'd0, o_rx_high_ber}, 8'd1);
        drive_n(2'b01, 15, 1'b1, "burst_rest");
        drive(2'b01, 1'b1);
        expect_end("burst_end", 1'b1, 6'd16);
        drive_n(2'b01, 31, 1'b1, "recover");
        drive(2'b01, 1'b1);
        expect_end("recover_end", 1'b0, 6'd0);

        // 15 invalid per window stays below threshold
        for (int w = 0; w < 4; w++) begin
            drive_n(2'b00, 15, 1'b0, "below");
            drive_n(2'b01, 16, 1'b0, "below_ok");
            drive(2'b01, 1'b1);
            expect_end("below_end", 1'b0, 6'd15);
        end

        // 16th invalid lands on the expiry cycle
        drive_n(2'b11, 15, 1'b0, "edge");
        drive_n(2'b01, 16, 1'b0, "edge_ok");
        drive(2'b11, 1'b1);
        expect_end("edge_end", 1'b1, 6'd16);
        drive_n(2'b11, 15, 1'b1, "edge_next");
        drive_n(2'b01, 16, 1'b1, "edge_next_ok");
        drive(2'b01, 1'b1);
        expect_end("edge_next_end", 1'b0, 6'd15);

        // Lock drop while in high BER
        drive_n(2'b11, 15, 1'b0, "lock_pre");
        drive(2'b11, 1'b1);
        chk("lock_hb_rise", {7'd0, o_rx_high_ber}, 8'd1);
        drive(2'b11, 1'b0);
        chk("lock_drop_hb",    {7'd0, o_rx_high_ber}, 8'd0);
        chk("lock_drop_count", {2'd0, o_ber_count},   8'd0);
        chk("lock_drop_done",  {7'd0, o_window_done}, 8'd0);
        drive(2'b01, 1'b1);
        chk("relock_done", {7'd0, o_window_done}, 8'd0);
        drive_n(2'b01, 31, 1'b0, "relock");
        drive(2'b01, 1'b1);
        expect_end("relock_end", 1'b0, 6'd0);

        // Every header invalid for three windows
        drive_n(2'b11, 15, 1'b0, "all_pre");
        drive(2'b11, 1'b1);
        chk("all_hb_rise", {7'd0, o_rx_high_ber}, 8'd1);
        drive_n(2'b11, 15, 1'b1, "all_w0");
        drive(2'b11, 1'b1);
        expect_end("all_end0", 1'b1, 6'd32);
        for (int w = 1; w < 3; w++) begin
            drive_n(2'b11, 31, 1'b1, "all_w");
            drive(2'b11, 1'b1);
            expect_end("all_end", 1'b1, 6'd32);
        end

        // Reset mid-window beats lock and discards the window
        drive_n(2'b11, 10, 1'b1, "mid");
        i_rst = 1'b1;
        drive(2'b11, 1'b1);
        chk("midrst_hb",    {7'd0, o_rx_high_ber}, 8'd0);
        chk("midrst_count", {2'd0, o_ber_count},   8'd0);
        chk("midrst_done",  {7'd0, o_window_done}, 8'd0);
        i_rst = 1'b0;
        drive(2'b11, 1'b1);
        chk("postrst_hb",   {7'd0, o_rx_high_ber}, 8'd0);
        chk("postrst_done", {7'd0, o_window_done}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
